// File: rtl/vga_list_pkg.sv
// Shared definitions for the VGA display-list format: terminator word, pointer
// address, writer FSM states and the bit fields of the three command words.
package vga_list_pkg;

   localparam logic [15:0] LIST_TERM = 16'hFFFF;
   localparam int          PTR_ADDR  = 0;

   typedef enum logic [2:0] {
      IDLE,
      COORD,
      COL,
      DIM,
      TERM,
      PTR,
      CLR
   } listState_e;

   // Field positions inside the coord, col and dim words; the list reader decodes the same slices.
   localparam int COORD_X_LSB    = 0;
   localparam int COORD_X_MSB    = 7;
   localparam int COORD_Y_LSB    = 9;
   localparam int COORD_Y_MSB    = 15;
   localparam int COL_ASCII_LSB  = 8;
   localparam int COL_ASCII_MSB  = 15;
   localparam int COL_TEXT_LSB   = 6;
   localparam int COL_TEXT_MSB   = 7;
   localparam int COL_COLOUR_LSB = 0;
   localparam int COL_COLOUR_MSB = 5;
   localparam int DIM_W_LSB      = 0;
   localparam int DIM_W_MSB      = 7;
   localparam int DIM_H_LSB      = 8;
   localparam int DIM_H_MSB      = 15;

   function automatic logic isTermWord(input logic [15:0] word);
      return word == LIST_TERM;
   endfunction

endpackage

// File: rtl/vga_list_writer_if.sv
// Command handshake from the CPU side plus the write port into the dual-port
// VGA memory. The master is the environment/CPU side, the slave is the list writer.
interface vga_list_writer_if #(
   parameter int ADDR_W = 10
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic [15:0]       cmd_coord;
   logic [15:0]       cmd_col;
   logic [15:0]       cmd_dim;

   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              mem_we;

   modport master (
      output cmd_valid,
      output cmd_coord,
      output cmd_col,
      output cmd_dim,
      input  cmd_ready,
      input  mem_addr,
      input  mem_wdata,
      input  mem_we
   );

   modport slave (
      input  cmd_valid,
      input  cmd_coord,
      input  cmd_col,
      input  cmd_dim,
      output cmd_ready,
      output mem_addr,
      output mem_wdata,
      output mem_we
   );

endinterface

// File: rtl/vga_list_writer.sv
// Serialises draw commands into the VGA display list and publishes it through word 0.
// Define VGA_LIST_AUTOTERM_EN to keep the list terminated (and published) after every command.
module vga_list_writer
   import vga_list_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int BASE        = 1,
   parameter int DEPTH       = 1024,
   parameter int MAX_ENTRIES = (DEPTH - BASE - 1) / 3
) (
   input  logic              clk,
   input  logic              reset,
   vga_list_writer_if.slave  bus,
   input  logic              commit_i,
   input  logic              clear_i,
   output logic              busy_o,
   output logic              full_o,
   output logic [ADDR_W-1:0] count_o,
   output logic              err_o
);

   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
   localparam logic [ADDR_W-1:0] MAX_A  = ADDR_W'(MAX_ENTRIES);
   localparam logic [ADDR_W-1:0] PTR_A  = ADDR_W'(PTR_ADDR);

   listState_e        state_q, state_d;
   logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic              err_q, err_d;
   logic [15:0]       col_q, dim_q;

   logic              memWe_q, memWe_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic [15:0]       memWdata_q, memWdata_d;

   logic              full;
   logic              cmdReady;
   logic              cmdFire;
   logic              cmdBad;

`ifdef VGA_LIST_AUTOTERM_EN
   logic              live_q, live_d;
   logic              fromCommit_q, fromCommit_d;
`endif

   assign full     = (count_q == MAX_A);
   assign cmdReady = (state_q == IDLE) && !full && !clear_i && !commit_i;
   assign cmdFire  = bus.cmd_valid && cmdReady;
   assign cmdBad   = isTermWord(bus.cmd_coord) || isTermWord(bus.cmd_col) ||
                     isTermWord(bus.cmd_dim);

   assign bus.cmd_ready = cmdReady;
   assign bus.mem_we    = memWe_q;
   assign bus.mem_addr  = memAddr_q;
   assign bus.mem_wdata = memWdata_q;

   assign busy_o  = (state_q != IDLE);
   assign full_o  = full;
   assign count_o = count_q;
   assign err_o   = err_q;

   // State, bookkeeping and the registered memory port all advance together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         wrPtr_q      <= BASE_A;
         count_q      <= '0;
         err_q        <= 1'b0;
         col_q        <= '0;
         dim_q        <= '0;
         memWe_q      <= 1'b0;
         memAddr_q    <= '0;
         memWdata_q   <= '0;
`ifdef VGA_LIST_AUTOTERM_EN
         live_q       <= 1'b0;
         fromCommit_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         wrPtr_q      <= wrPtr_d;
         count_q      <= count_d;
         err_q        <= err_d;
         memWe_q      <= memWe_d;
         memAddr_q    <= memAddr_d;
         memWdata_q   <= memWdata_d;
`ifdef VGA_LIST_AUTOTERM_EN
         live_q       <= live_d;
         fromCommit_q <= fromCommit_d;
`endif
         if (cmdFire) begin
            col_q <= bus.cmd_col;
            dim_q <= bus.cmd_dim;
         end
      end
   end

   // Next state: IDLE arbitrates clear over commit over a new command; every other state lasts one cycle.
   always_comb begin
      state_d = state_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      err_d   = err_q;
`ifdef VGA_LIST_AUTOTERM_EN
      live_d       = live_q;
      fromCommit_d = fromCommit_q;
`endif
      unique case (state_q)
         IDLE: begin
`ifdef VGA_LIST_AUTOTERM_EN
            fromCommit_d = commit_i && !clear_i;
`endif
            if (clear_i) begin
               state_d = CLR;
            end else if (commit_i) begin
               state_d = TERM;
            end else if (cmdFire) begin
               if (cmdBad) begin
                  err_d = 1'b1;
               end else begin
                  state_d = COORD;
               end
            end
         end
         COORD: state_d = COL;
         COL:   state_d = DIM;
         DIM: begin
            wrPtr_d = wrPtr_q + ADDR_W'(3);
            count_d = count_q + ADDR_W'(1);
`ifdef VGA_LIST_AUTOTERM_EN
            state_d = TERM;
`else
            state_d = IDLE;
`endif
         end
         TERM: begin
`ifdef VGA_LIST_AUTOTERM_EN
            state_d = (fromCommit_q || !live_q) ? PTR : IDLE;
`else
            state_d = PTR;
`endif
         end
         PTR: begin
`ifdef VGA_LIST_AUTOTERM_EN
            live_d = 1'b1;
`endif
            state_d = IDLE;
         end
         CLR: begin
            wrPtr_d = BASE_A;
            count_d = '0;
            err_d   = 1'b0;
`ifdef VGA_LIST_AUTOTERM_EN
            live_d  = 1'b0;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory write for the state being entered, so the port is registered yet lines up with that state.
   always_comb begin
      memWe_d    = 1'b0;
      memAddr_d  = '0;
      memWdata_d = '0;
      unique case (state_d)
         COORD: begin
            memWe_d    = 1'b1;
            memAddr_d  = wrPtr_q;
            memWdata_d = bus.cmd_coord;
         end
         COL: begin
            memWe_d    = 1'b1;
            memAddr_d  = wrPtr_q + ADDR_W'(1);
            memWdata_d = col_q;
         end
         DIM: begin
            memWe_d    = 1'b1;
            memAddr_d  = wrPtr_q + ADDR_W'(2);
            memWdata_d = dim_q;
         end
         TERM: begin
            memWe_d    = 1'b1;
            memAddr_d  = wrPtr_d;
            memWdata_d = LIST_TERM;
         end
         PTR: begin
            memWe_d    = 1'b1;
            memAddr_d  = PTR_A;
            memWdata_d = 16'(BASE);
         end
         CLR: begin
            memWe_d    = 1'b1;
            memAddr_d  = PTR_A;
            memWdata_d = 16'h0000;
         end
         default: begin
            memWe_d    = 1'b0;
            memAddr_d  = '0;
            memWdata_d = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_vga_list_writer.sv
// Self-checking bench for vga_list_writer: directed scenarios plus random commands,
// compared against a write-list model that tracks the display list at entry level.
module tb_vga_list_writer;

   localparam int ADDR_W      = 10;
   localparam int BASE        = 1;
   localparam int DEPTH       = 16;
   localparam int MAX_ENTRIES = (DEPTH - BASE - 1) / 3;
`ifdef VGA_LIST_AUTOTERM_EN
   localparam bit AUTO_TERM = 1'b1;
`else
   localparam bit AUTO_TERM = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              commit;
   logic              clear;
   logic              busy;
   logic              full;
   logic [ADDR_W-1:0] count;
   logic              err;

   vga_list_writer_if #(.ADDR_W(ADDR_W)) bus ();

   vga_list_writer #(
      .ADDR_W (ADDR_W),
      .BASE   (BASE),
      .DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .commit_i (commit),
      .clear_i  (clear),
      .busy_o   (busy),
      .full_o   (full),
      .count_o  (count),
      .err_o    (err)
   );

   always #5 clk = ~clk;

   int          passCount = 0;
   int          checkCount = 0;
   logic [31:0] expQ[$];
   logic [31:0] obsQ[$];
   int          modelCount;
   bit          modelErr;
   bit          modelLive;

   // Every memory write the DUT issues, as {addr, data}, sampled just after the edge.
   always @(posedge clk) begin
      #1;
      if (bus.mem_we === 1'b1) obsQ.push_back({16'(bus.mem_addr), bus.mem_wdata});
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] wr(input int addr, input logic [15:0] data);
      return {16'(addr), data};
   endfunction

   function automatic int ptrNow();
      return BASE + 3 * modelCount;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) begin
         passCount++;
      end else begin
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkWrites(input string tag);
      checkOutput($sformatf("%s nwrites", tag), 32'(obsQ.size()), 32'(expQ.size()));
      for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
         checkOutput($sformatf("%s write%0d", tag, i), obsQ[i], expQ[i]);
      obsQ.delete();
      expQ.delete();
   endtask

   task automatic checkStatus(input string tag);
      checkOutput($sformatf("%s count", tag), 32'(count), 32'(modelCount));
      checkOutput($sformatf("%s err", tag), 32'(err), 32'(modelErr));
      checkOutput($sformatf("%s full", tag), 32'(full), 32'(modelCount == MAX_ENTRIES));
      checkOutput($sformatf("%s ready", tag), 32'(bus.cmd_ready), 32'(modelCount != MAX_ENTRIES));
   endtask

   task automatic modelClear();
      expQ.push_back(wr(0, 16'h0000));
      modelCount = 0;
      modelErr   = 1'b0;
      modelLive  = 1'b0;
   endtask

   task automatic modelCommit();
      expQ.push_back(wr(ptrNow(), 16'hFFFF));
      expQ.push_back(wr(0, 16'(BASE)));
      modelLive = 1'b1;
   endtask

   task automatic modelCmd(input logic [15:0] c, input logic [15:0] col, input logic [15:0] d,
                           output bit accepted);
      accepted = (modelCount < MAX_ENTRIES);
      if (accepted) begin
         if (c == 16'hFFFF || col == 16'hFFFF || d == 16'hFFFF) begin
            modelErr = 1'b1;
         end else begin
            expQ.push_back(wr(ptrNow(), c));
            expQ.push_back(wr(ptrNow() + 1, col));
            expQ.push_back(wr(ptrNow() + 2, d));
            modelCount++;
            if (AUTO_TERM) begin
               expQ.push_back(wr(ptrNow(), 16'hFFFF));
               if (!modelLive) begin
                  expQ.push_back(wr(0, 16'(BASE)));
                  modelLive = 1'b1;
               end
            end
         end
      end
   endtask

   // All driving tasks start and end at a falling edge.
   task automatic waitIdle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput($sformatf("%s idle", tag), 32'(busy), 32'(0));
   endtask

   task automatic applyStimulus(input logic [15:0] c, input logic [15:0] col, input logic [15:0] d,
                                output bit accepted);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_coord = c;
      bus.cmd_col   = col;
      bus.cmd_dim   = d;
      while (bus.cmd_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      accepted = (bus.cmd_ready === 1'b1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic pulseClear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      waitIdle("clear");
   endtask

   task automatic pulseCommit();
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      waitIdle("commit");
   endtask

   task automatic sendAndModel(input string tag, input logic [15:0] c, input logic [15:0] col,
                               input logic [15:0] d);
      bit acc, expAcc;
      modelCmd(c, col, d, expAcc);
      applyStimulus(c, col, d, acc);
      checkOutput($sformatf("%s accepted", tag), 32'(acc), 32'(expAcc));
      waitIdle(tag);
   endtask

   initial begin
      bit          acc;
      logic [15:0] rc, rcol, rd;
      int          op;

      reset         = 1'b1;
      commit        = 1'b0;
      clear         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_coord = '0;
      bus.cmd_col   = '0;
      bus.cmd_dim   = '0;
      modelCount    = 0;
      modelErr      = 1'b0;
      modelLive     = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset we", 32'(bus.mem_we), 32'(0));
      checkOutput("reset addr", 32'(bus.mem_addr), 32'(0));
      checkOutput("reset wdata", 32'(bus.mem_wdata), 32'(0));
      checkOutput("reset busy", 32'(busy), 32'(0));
      checkStatus("reset");
      reset = 1'b0;
      @(negedge clk);
      checkWrites("reset");

      $display("[TB] scenario 1: single command then commit");
      modelClear();
      pulseClear();
      sendAndModel("s1 cmd", 16'h0A14, 16'h0007, 16'h0503);
      modelCommit();
      pulseCommit();
      checkWrites("s1");
      checkStatus("s1");

      $display("[TB] scenario 2: commit of an empty list");
      modelClear();
      pulseClear();
      modelCommit();
      pulseCommit();
      checkWrites("s2");
      checkStatus("s2");

      $display("[TB] scenario 3: command carrying the terminator word");
      sendAndModel("s3 cmd", 16'h1234, 16'hFFFF, 16'h0101);
      checkWrites("s3");
      checkStatus("s3");
      modelClear();
      pulseClear();
      checkWrites("s3 clear");
      checkStatus("s3 clear");

      $display("[TB] scenario 4: fill to capacity back to back");
      for (int i = 0; i < MAX_ENTRIES + 1; i++) begin
         bit expAcc;
         rc   = 16'($urandom_range(0, 16'hFFFE));
         rcol = 16'($urandom_range(0, 16'hFFFE));
         rd   = 16'($urandom_range(0, 16'hFFFE));
         modelCmd(rc, rcol, rd, expAcc);
         applyStimulus(rc, rcol, rd, acc);
         checkOutput($sformatf("s4 accepted%0d", i), 32'(acc), 32'(expAcc));
      end
      waitIdle("s4");
      checkStatus("s4 full");
      modelCommit();
      pulseCommit();
      checkWrites("s4");

      $display("[TB] scenario 5: clear and commit together");
      clear  = 1'b1;
      commit = 1'b1;
      modelClear();
      @(negedge clk);
      clear  = 1'b0;
      commit = 1'b0;
      waitIdle("s5");
      repeat (3) @(negedge clk);
      checkWrites("s5");
      checkStatus("s5");

      $display("[TB] random phase");
      for (int i = 0; i < 14; i++) begin
         op   = int'($urandom_range(0, 19));
         rc   = 16'($urandom);
         rcol = 16'($urandom);
         rd   = 16'($urandom);
         if ($urandom_range(0, 4) == 0) rcol = 16'hFFFF;
         if (op < 14) begin
            sendAndModel($sformatf("rnd%0d cmd", i), rc, rcol, rd);
         end else if (op < 18) begin
            modelCommit();
            pulseCommit();
         end else begin
            modelClear();
            pulseClear();
         end
         checkWrites($sformatf("rnd%0d", i));
         checkStatus($sformatf("rnd%0d", i));
      end

      $display("[TB] scenario 6: reset in the middle of a command");
      modelClear();
      pulseClear();
      checkWrites("s6 clear");
      rc   = 16'h2233;
      rcol = 16'h4455;
      rd   = 16'h0201;
      applyStimulus(rc, rcol, rd, acc);
      checkOutput("s6 accepted", 32'(acc), 32'(1));
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("s6 reset we", 32'(bus.mem_we), 32'(0));
      checkOutput("s6 reset addr", 32'(bus.mem_addr), 32'(0));
      checkOutput("s6 reset wdata", 32'(bus.mem_wdata), 32'(0));
      checkOutput("s6 reset busy", 32'(busy), 32'(0));
      expQ.push_back(wr(BASE, rc));
      expQ.push_back(wr(BASE + 1, rcol));
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      checkWrites("s6");
      modelCount = 0;
      modelErr   = 1'b0;
      modelLive  = 1'b0;
      checkStatus("s6");

      sendAndModel("s6 after", 16'h0C0D, 16'h4103, 16'h0404);
      checkWrites("s6 after");
      modelCommit();
      pulseCommit();
      checkWrites("s6 commit");
      checkStatus("s6 commit");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/vga_list_writer.md
Name: vga_list_writer

Overview:
- Producer side of the VGA display-list memory format.
- Accepts rectangle/text draw commands (coord, colour, dimension words) from the CPU side over a valid/ready handshake.
- Serialises each command into consecutive memory words, appends the 0xFFFF terminator, and publishes the list by writing its start offset into word 0.
- Drives one write port of the dual-port VGA memory; the list-reading block consumes the other port.

Parameters:
- ADDR_W, 10, memory address width.
- BASE, 1, first list word address; must be nonzero because word 0 is the list pointer.
- DEPTH, 1024, number of memory words.
- MAX_ENTRIES, (DEPTH-BASE-1)/3, command capacity; one word is reserved for the terminator.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on the cycle where valid && ready.
- cmd_coord  in  16  [7:0] x, [15:9] y.
- cmd_col  in  16  [15:8] ascii, [7:6] text flag, [5:0] colour.
- cmd_dim  in  16  [7:0] width, [15:8] height.
- commit  in  1  single-cycle pulse: terminate and publish the list.
- clear  in  1  single-cycle pulse: unpublish and empty the list.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  write data.
- mem_we  out  1  write strobe.
- busy  out  1  state != IDLE.
- full  out  1  entry count == MAX_ENTRIES.
- count  out  ADDR_W  entries appended since the last clear.
- err  out  1  sticky flag: a command was rejected.

Behaviour:
- Outputs:
  - All memory outputs are registered; one memory write per cycle, at most.
- Reset (asynchronous):
  - state=IDLE, wr_ptr=BASE, count=0, err=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, busy=0, full=0.
  - Reset does not write memory; software issues clear after reset.
  - Reset mid-sequence aborts with no further writes. A partially written entry is harmless because word 0 is untouched until commit.
- Handshake:
  - cmd_ready = (state==IDLE) && !full && !clear && !commit.
  - The payload is captured into holding registers on acceptance.
  - A command in which any of the three words equals 16'hFFFF is accepted but discarded. It sets err, writes nothing, and leaves count unchanged.
- States and transitions (cycle N = command acceptance):
  - IDLE: clear -> CLR; else commit -> TERM; else accepted command -> COORD.
  - COORD (N+1): we=1, addr=wr_ptr, data=coord.
  - COL (N+2): addr=wr_ptr+1, data=col.
  - DIM (N+3): addr=wr_ptr+2, data=dim. On exit wr_ptr+=3, count+=1.
  - Return to IDLE at N+4; cmd_ready is high again at N+4 unless full.
  - TERM: addr=wr_ptr, data=16'hFFFF -> PTR.
  - PTR: addr=0, data=BASE -> IDLE. The list is now visible to the reader.
  - CLR: addr=0, data=0 (reader idles); wr_ptr=BASE, count=0, err=0 -> IDLE.
- Priority in IDLE:
  - clear > commit > cmd.
  - clear or commit asserted while busy is ignored; callers wait for !busy.
- Boundaries:
  - full when count==MAX_ENTRIES. The terminator slot always remains, so commit is legal when full.
  - Commit with count==0 writes 0xFFFF at BASE, then the pointer: an empty published list.
  - Repeated commit without clear rewrites the terminator at the current wr_ptr. Appending after commit therefore extends the live list, and the next commit moves the terminator.
  - Address arithmetic is ADDR_W bits wide. wr_ptr+2 never exceeds DEPTH-2 by construction of MAX_ENTRIES.

Optional Feature:
- Macro: VGA_LIST_AUTOTERM_EN.
- Defined:
  - After DIM, an extra TERM state writes 0xFFFF at the new wr_ptr.
  - On the first entry after a clear, a PTR state follows the terminator write.
  - The list is always live, with 1-2 extra cycles per command.
  - commit still performs TERM+PTR and stays legal.
- Undefined:
  - Terminator and pointer are written only on commit, as described above.

Decomposition:
- Package vga_list_pkg holds:
  - LIST_TERM=16'hFFFF and PTR_ADDR=0.
  - The state enum (IDLE, COORD, COL, DIM, TERM, PTR, CLR).
  - Field-slice constants for coord, col and dim, shared with the list reader.
- No sub-module is needed: a single FSM with a small write-mux.

Test Plan:
1. Reset, clear, one command coord=16'h0A14, col=16'h0007, dim=16'h0503, then commit.
   - Writes in order: [0]=0000; [1]=0A14; [2]=0007; [3]=0503; [4]=FFFF; [0]=0001.
   - count=1.
2. Commit immediately after clear -> [1]=FFFF, [0]=0001, count=0.
3. Command with col=16'hFFFF -> no mem_we pulse, err=1, count unchanged; a following clear returns err to 0.
4. Fill the list with DEPTH=16, BASE=1 (MAX_ENTRIES=4) using 5 back-to-back commands.
   - 4 accepted; cmd_ready low after the 4th; full=1.
   - Commit then writes FFFF at address 13.
5. clear and commit asserted in the same IDLE cycle -> only the CLR write ([0]=0000) occurs; the commit is dropped.
6. Assert reset during COL -> outputs zero on the next edge, with no further writes. Under VGA_LIST_AUTOTERM_EN, one command yields FFFF at address 4 and [0]=0001 without any commit.
